// File: rtl/screen_sequencer_if.sv
// Signal bundle between the game logic / palette pixel path and the screen sequencer.
// The master drives events and palette pixels. The slave returns faded RGB and screen control.
interface screen_sequencer_if;
    logic       frame_start;
    logic       start_btn;
    logic       player_dead;
    logic       level_clear;
    logic       blank;
    logic [3:0] pal_red;
    logic [3:0] pal_green;
    logic [3:0] pal_blue;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic [1:0] screen_sel;
    logic [4:0] fade_level;
    logic       game_run;
    logic       level_advance;

    modport master (
        output frame_start, start_btn, player_dead, level_clear, blank,
        output pal_red, pal_green, pal_blue,
        input  red, green, blue, screen_sel, fade_level, game_run, level_advance
    );

    modport slave (
        input  frame_start, start_btn, player_dead, level_clear, blank,
        input  pal_red, pal_green, pal_blue,
        output red, green, blue, screen_sel, fade_level, game_run, level_advance
    );
endinterface

// File: rtl/screen_sequencer.sv
// Display-phase controller: steps title/play/game-over/win screens with a frame-counted
// fade-out/fade-in, and applies the fade to the palette colour feeding the VGA register.
module screen_sequencer #(
    parameter int FADE_STEP_FRAMES = 1,
    parameter int HOLD_FRAMES      = 180
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    screen_sequencer_if.slave bus
);

    localparam int SW = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
    localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(FADE_STEP_FRAMES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES);

    localparam logic [1:0] SCR_TITLE    = 2'd0;
    localparam logic [1:0] SCR_PLAY     = 2'd1;
    localparam logic [1:0] SCR_GAMEOVER = 2'd2;
    localparam logic [1:0] SCR_WIN      = 2'd3;

    typedef enum logic [2:0] {
        ST_TITLE,
        ST_PLAY,
        ST_GAMEOVER,
        ST_WIN,
        ST_FADE_OUT,
        ST_FADE_IN
    } state_t;

    state_t        state_reg;
    logic [1:0]    target_reg;
    logic [1:0]    screen_sel_reg;
    logic [4:0]    fade_reg;
    logic          game_run_reg;
    logic          level_advance_reg;
    logic [SW-1:0] step_reg;
    logic [HW-1:0] hold_reg;
    logic          start_prev_reg;
    logic [3:0]    red_reg;
    logic [3:0]    green_reg;
    logic [3:0]    blue_reg;

    logic start_edge;
    logic hold_expired;

    assign start_edge   = bus.start_btn & ~start_prev_reg;
    assign hold_expired = (hold_reg == HOLD_LAST);

    // (c * fade) >> 4; 15 * 16 fits in 8 bits, so the 9-bit product never overflows.
    function automatic logic [3:0] fade_chan(input logic [3:0] c, input logic [4:0] f);
        return 4'((9'(c) * 9'(f)) >> 4);
    endfunction

    function automatic state_t screen_state(input logic [1:0] sel);
        case (sel)
            SCR_PLAY:     return ST_PLAY;
            SCR_GAMEOVER: return ST_GAMEOVER;
            SCR_WIN:      return ST_WIN;
            default:      return ST_TITLE;
        endcase
    endfunction

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= ST_TITLE;
            target_reg        <= SCR_TITLE;
            screen_sel_reg    <= SCR_TITLE;
            fade_reg          <= 5'd16;
            game_run_reg      <= 1'b0;
            level_advance_reg <= 1'b0;
            step_reg          <= '0;
            hold_reg          <= '0;
            start_prev_reg    <= 1'b0;
            red_reg           <= '0;
            green_reg         <= '0;
            blue_reg          <= '0;
        end else begin
            start_prev_reg    <= bus.start_btn;
            level_advance_reg <= 1'b0;
            red_reg           <= bus.blank ? fade_chan(bus.pal_red,   fade_reg) : 4'd0;
            green_reg         <= bus.blank ? fade_chan(bus.pal_green, fade_reg) : 4'd0;
            blue_reg          <= bus.blank ? fade_chan(bus.pal_blue,  fade_reg) : 4'd0;

            // Every state change below also clears the step and hold counters.
            case (state_reg)
                ST_TITLE: begin
                    if (start_edge) begin
                        target_reg <= SCR_PLAY;
                        state_reg  <= ST_FADE_OUT;
                        step_reg   <= '0;
                        hold_reg   <= '0;
                    end
                end
                ST_PLAY: begin
                    if (bus.level_clear || bus.player_dead) begin
                        target_reg   <= bus.level_clear ? SCR_WIN : SCR_GAMEOVER;
                        state_reg    <= ST_FADE_OUT;
                        game_run_reg <= 1'b0;
                        step_reg     <= '0;
                        hold_reg     <= '0;
                    end
                end
                ST_GAMEOVER: begin
                    if (hold_expired && start_edge) begin
                        target_reg <= SCR_TITLE;
                        state_reg  <= ST_FADE_OUT;
                        step_reg   <= '0;
                        hold_reg   <= '0;
                    end else if (bus.frame_start && !hold_expired) begin
                        hold_reg <= hold_reg + 1'b1;
                    end
                end
                ST_WIN: begin
                    if (hold_expired) begin
                        target_reg        <= SCR_PLAY;
                        level_advance_reg <= 1'b1;
                        state_reg         <= ST_FADE_OUT;
                        step_reg          <= '0;
                        hold_reg          <= '0;
                    end else if (bus.frame_start) begin
                        hold_reg <= hold_reg + 1'b1;
                    end
                end
                ST_FADE_OUT: begin
                    if (bus.frame_start) begin
                        if (step_reg == STEP_LAST) begin
                            step_reg <= '0;
                            fade_reg <= fade_reg - 5'd1;
                            // Screen swaps only at full black.
                            if (fade_reg == 5'd1) begin
                                screen_sel_reg <= target_reg;
                                state_reg      <= ST_FADE_IN;
                                hold_reg       <= '0;
                            end
                        end else begin
                            step_reg <= step_reg + 1'b1;
                        end
                    end
                end
                ST_FADE_IN: begin
                    if (bus.frame_start) begin
                        if (step_reg == STEP_LAST) begin
                            step_reg <= '0;
                            fade_reg <= fade_reg + 5'd1;
                            if (fade_reg == 5'd15) begin
                                state_reg    <= screen_state(screen_sel_reg);
                                game_run_reg <= (screen_sel_reg == SCR_PLAY);
                                hold_reg     <= '0;
                            end
                        end else begin
                            step_reg <= step_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_TITLE;
                    step_reg  <= '0;
                    hold_reg  <= '0;
                end
            endcase
        end
    end

    assign bus.red           = red_reg;
    assign bus.green         = green_reg;
    assign bus.blue          = blue_reg;
    assign bus.screen_sel    = screen_sel_reg;
    assign bus.fade_level    = fade_reg;
    assign bus.game_run      = game_run_reg;
    assign bus.level_advance = level_advance_reg;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer: expected values are queued when stimulus is
// applied and popped against DUT outputs sampled on the falling clock edge.
module tb_screen_sequencer;

    logic vga_clk;
    logic reset_n;

    screen_sequencer_if bus ();

    screen_sequencer #(
        .FADE_STEP_FRAMES (1),
        .HOLD_FRAMES      (4)
    ) dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    typedef struct {
        string tag;
        int    exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_eval = 0;
    int   n_fail = 0;
    int   adv_cnt = 0;

    always @(negedge vga_clk) begin
        if (bus.level_advance === 1'b1) adv_cnt++;
    end

    task automatic push(input string tag, input int exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input int obs);
        exp_t e;
        n_eval++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0d required an expectation", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge vga_clk);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            bus.frame_start = 1'b1;
            @(negedge vga_clk);
            bus.frame_start = 1'b0;
            @(negedge vga_clk);
        end
    endtask

    task automatic press_start();
        bus.start_btn = 1'b1;
        @(negedge vga_clk);
        bus.start_btn = 1'b0;
        @(negedge vga_clk);
    endtask

    initial begin
        int base;
        reset_n         = 1'b0;
        bus.frame_start = 1'b0;
        bus.start_btn   = 1'b0;
        bus.player_dead = 1'b0;
        bus.level_clear = 1'b0;
        bus.blank       = 1'b1;
        bus.pal_red     = 4'hF;
        bus.pal_green   = 4'h8;
        bus.pal_blue    = 4'h1;
        tick(3);

        // Reset values while held in reset
        push("rst_fade", 16); push("rst_sel", 0); push("rst_red", 0); push("rst_run", 0);
        pop_chk(bus.fade_level); pop_chk(bus.screen_sel); pop_chk(bus.red); pop_chk(bus.game_run);

        // Title entry: full-brightness pass-through one cycle after release
        reset_n = 1'b1;
        push("title_red", 15); push("title_green", 8); push("title_blue", 1);
        push("title_sel", 0); push("title_run", 0);
        tick(1);
        pop_chk(bus.red); pop_chk(bus.green); pop_chk(bus.blue);
        pop_chk(bus.screen_sel); pop_chk(bus.game_run);

        // Start -> fade out to play
        press_start();
        frames(15);
        push("fo_fade15", 1); push("fo_sel_hold", 0);
        pop_chk(bus.fade_level); pop_chk(bus.screen_sel);
        frames(1);
        push("fo_fade0", 0); push("fo_sel_play", 1);
        pop_chk(bus.fade_level); pop_chk(bus.screen_sel);
        tick(1);
        push("black_red", 0);
        pop_chk(bus.red);

        // Fade in; at fade 8: F->7, 8->4, 1->0
        frames(8);
        tick(1);
        push("fi8_fade", 8); push("fi8_red", 7); push("fi8_green", 4); push("fi8_blue", 0);
        push("fi8_run", 0);
        pop_chk(bus.fade_level); pop_chk(bus.red); pop_chk(bus.green); pop_chk(bus.blue);
        pop_chk(bus.game_run);
        frames(8);
        push("play_fade", 16); push("play_run", 1);
        pop_chk(bus.fade_level); pop_chk(bus.game_run);

        // Blanking forces black
        bus.blank = 1'b0;
        tick(1);
        push("blank_red", 0);
        pop_chk(bus.red);
        bus.blank = 1'b1;
        bus.pal_red = 4'hA;
        tick(1);
        push("unblank_red", 10);
        pop_chk(bus.red);

        // Simultaneous dead + clear: level_clear wins; game_run drops at once
        bus.player_dead = 1'b1;
        bus.level_clear = 1'b1;
        tick(1);
        bus.player_dead = 1'b0;
        bus.level_clear = 1'b0;
        push("both_run", 0); push("both_fade", 16);
        pop_chk(bus.game_run); pop_chk(bus.fade_level);
        frames(5);
        bus.player_dead = 1'b1;
        tick(1);
        bus.player_dead = 1'b0;
        tick(1);
        push("midfade_fade", 11);
        pop_chk(bus.fade_level);
        frames(11);
        push("win_sel", 3); push("win_fade0", 0);
        pop_chk(bus.screen_sel); pop_chk(bus.fade_level);
        frames(16);
        push("win_fade16", 16); push("win_run", 0);
        pop_chk(bus.fade_level); pop_chk(bus.game_run);

        // Win hold: no advance before 4 frames, exactly one pulse after
        base = adv_cnt;
        frames(3);
        tick(2);
        push("win_hold_adv", base); push("win_hold_fade", 16);
        pop_chk(adv_cnt); pop_chk(bus.fade_level);
        frames(1);
        tick(2);
        push("win_adv_once", base + 1);
        pop_chk(adv_cnt);
        frames(16);
        push("adv_sel", 1); push("adv_fade0", 0);
        pop_chk(bus.screen_sel); pop_chk(bus.fade_level);
        frames(16);
        push("adv_run", 1); push("adv_total", base + 1);
        pop_chk(bus.game_run); pop_chk(adv_cnt);

        // Game over, early start edge discarded
        bus.player_dead = 1'b1;
        tick(1);
        bus.player_dead = 1'b0;
        frames(32);
        push("go_sel", 2); push("go_fade", 16); push("go_run", 0);
        pop_chk(bus.screen_sel); pop_chk(bus.fade_level); pop_chk(bus.game_run);
        frames(2);
        press_start();
        tick(3);
        push("go_early_fade", 16); push("go_early_sel", 2);
        pop_chk(bus.fade_level); pop_chk(bus.screen_sel);
        frames(2);
        press_start();
        frames(1);
        push("go_exit_fade", 15);
        pop_chk(bus.fade_level);
        frames(15);
        push("go_title_sel", 0); push("go_title_fade", 0);
        pop_chk(bus.screen_sel); pop_chk(bus.fade_level);
        frames(16);

        // Back in title; start again and reset at fade 5
        press_start();
        frames(11);
        push("pre_rst_fade", 5);
        pop_chk(bus.fade_level);
        #2;
        reset_n = 1'b0;
        #1;
        push("async_fade", 16); push("async_sel", 0); push("async_red", 0);
        push("async_green", 0);
        pop_chk(bus.fade_level); pop_chk(bus.screen_sel); pop_chk(bus.red); pop_chk(bus.green);
        tick(2);
        reset_n = 1'b1;
        frames(3);
        push("post_rst_fade", 16); push("post_rst_red", 10); push("post_rst_run", 0);
        pop_chk(bus.fade_level); pop_chk(bus.red); pop_chk(bus.game_run);

        if (exp_q.size() != 0) begin
            n_eval++;
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d entries required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
